// File: rtl/operand_stage.sv
// Decode/operand-read stage: register file, NUM_FWD-way forwarding, load-use stall, registered valid/ready output.
// Optional: OPERAND_STAGE_PERF_EN adds the stall_cycles hazard counter.
module operand_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_FWD   = 3,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic [5*NUM_FWD-1:0]    fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    input  logic                    wb_en,
    input  logic [4:0]              wb_addr,
    input  logic [XLEN-1:0]         wb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instr,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_rs1_data,
    output logic [XLEN-1:0]         out_rs2_data
`ifdef OPERAND_STAGE_PERF_EN
    ,
    output logic [31:0]             stall_cycles
`endif
);

    logic [XLEN-1:0] regs [1:31];
    logic [6:0]      opcode;
    logic [4:0]      rs [2];
    logic            rs_used [2];
    logic [XLEN-1:0] op_data [2];
    logic            op_pending [2];
    logic            found;
    logic            hazard;
    logic            accept;

    assign opcode = in_instr[6:0];
    assign rs[0]  = in_instr[19:15];
    assign rs[1]  = in_instr[24:20];

    always_comb begin
        rs_used[0] = !(opcode == 7'b0110111 || opcode == 7'b0010111 || opcode == 7'b1101111);
        rs_used[1] = (opcode == 7'b0110011 || opcode == 7'b0100011 || opcode == 7'b1100011);
    end

    // Youngest matching forwarding source wins; its pending bit decides the hazard,
    // so an older pending match hidden behind a ready younger one never stalls.
    always_comb begin
        found = 1'b0;
        for (int unsigned k = 0; k < 2; k++) begin
            op_data[k]    = '0;
            op_pending[k] = 1'b0;
            found         = 1'b0;
            if (rs[k] != 5'd0) begin
                for (int unsigned i = 0; i < NUM_FWD; i++) begin
                    if (!found && fwd_valid[i] && fwd_rd[5*i +: 5] == rs[k]) begin
                        found         = 1'b1;
                        op_data[k]    = fwd_data[XLEN*i +: XLEN];
                        op_pending[k] = fwd_pending[i];
                    end
                end
                if (!found) begin
                    if (wb_en && wb_addr == rs[k])
                        op_data[k] = wb_data;
                    else
                        op_data[k] = regs[rs[k]];
                end
            end
        end
    end

    always_comb begin
        hazard   = in_valid && ((rs_used[0] && op_pending[0]) || (rs_used[1] && op_pending[1]));
        in_ready = !flush && !hazard && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < 32; i++)
                regs[i] <= '0;
        end else if (wb_en && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_instr    <= NOP_INSTR;
            out_pc       <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_instr    <= in_instr;
            out_pc       <= in_pc;
            out_rs1_data <= op_data[0];
            out_rs2_data <= op_data[1];
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
        end
    end

`ifdef OPERAND_STAGE_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (hazard && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed scenarios followed by randomized traffic against a behavioural model.
module tb_operand_stage;

    localparam int NF = 3;
    localparam logic [31:0] NOP = 32'h0000_0033;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_instr = NOP;
    logic [31:0]   in_pc = '0;
    logic [NF-1:0] fwd_valid = '0;
    logic [NF-1:0] fwd_pending = '0;
    logic [5*NF-1:0]  fwd_rd = '0;
    logic [32*NF-1:0] fwd_data = '0;
    logic          wb_en = 1'b0;
    logic [4:0]    wb_addr = '0;
    logic [31:0]   wb_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_instr, out_pc, out_rs1_data, out_rs2_data;
`ifdef OPERAND_STAGE_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    operand_stage #(.XLEN(32), .NUM_FWD(NF), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
`ifdef OPERAND_STAGE_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [31:0] mregs [32];
    logic        m_valid;
    logic [31:0] m_instr, m_pc, m_rs1, m_rs2, m_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] r1, input logic [4:0] r2);
        return {7'b0, r2, r1, 3'b0, rd, op};
    endfunction

    // Priority: x0, youngest forwarding match, writeback port, register file.
    task automatic msel(input logic [4:0] r, output logic [31:0] d, output logic p);
        d = '0;
        p = 1'b0;
        if (r == 5'd0) return;
        for (int i = 0; i < NF; i++) begin
            if (fwd_valid[i] && fwd_rd[5*i +: 5] == r) begin
                d = fwd_data[32*i +: 32];
                p = fwd_pending[i];
                return;
            end
        end
        if (wb_en && wb_addr == r) d = wb_data;
        else d = mregs[r];
    endtask

    task automatic model_reset();
        foreach (mregs[i]) mregs[i] = '0;
        m_valid = 1'b0; m_instr = NOP; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_stall = '0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, ".out_valid"}, {31'b0, out_valid}, {31'b0, m_valid});
        check({pfx, ".out_instr"}, out_instr, m_instr);
        check({pfx, ".out_pc"}, out_pc, m_pc);
        check({pfx, ".rs1"}, out_rs1_data, m_rs1);
        check({pfx, ".rs2"}, out_rs2_data, m_rs2);
`ifdef OPERAND_STAGE_PERF_EN
        check({pfx, ".stall_cycles"}, stall_cycles, m_stall);
`endif
    endtask

    // One clock: check in_ready, advance the model across the edge, check outputs.
    task automatic step(input string pfx);
        logic [31:0] d1, d2;
        logic p1, p2, u1, u2, hz, rdy, acc;
        logic [6:0] op;
        #1;
        op = in_instr[6:0];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
        u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        msel(in_instr[19:15], d1, p1);
        msel(in_instr[24:20], d2, p2);
        hz  = in_valid && ((u1 && p1) || (u2 && p2));
        rdy = !flush && !hz && (!m_valid || out_ready);
        acc = in_valid && rdy;
        check({pfx, ".in_ready"}, {31'b0, in_ready}, {31'b0, rdy});
        @(posedge clk);
        if (wb_en && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
        if (flush) begin
            m_valid = 1'b0; m_instr = NOP;
        end else if (acc) begin
            m_valid = 1'b1; m_instr = in_instr; m_pc = in_pc; m_rs1 = d1; m_rs2 = d2;
        end else if (out_ready) begin
            m_valid = 1'b0; m_instr = NOP;
        end
        if (hz && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        #1;
        check_outputs(pfx);
    endtask

    task automatic set_fwd(input int i, input logic v, input logic p,
                           input logic [4:0] rd, input logic [31:0] d);
        fwd_valid[i] = v;
        fwd_pending[i] = p;
        fwd_rd[5*i +: 5] = rd;
        fwd_data[32*i +: 32] = d;
    endtask

    task automatic clear_in();
        fwd_valid = '0; fwd_pending = '0; fwd_rd = '0; fwd_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    endtask

    logic [6:0] ops [8] = '{7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6f};

    initial begin
        model_reset();
        #12;
        check_outputs("reset");
        reset = 1'b0;

        // Three-way match on x5: youngest matching source fwd[1] wins
        clear_in();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h11;
        set_fwd(2, 1'b1, 1'b0, 5'd5, 32'h22);
        set_fwd(1, 1'b1, 1'b0, 5'd5, 32'h33);
        set_fwd(0, 1'b1, 1'b0, 5'd9, 32'h44);
        in_valid = 1'b1; in_instr = mk(7'h33, 5'd6, 5'd5, 5'd5); in_pc = 32'h100;
        step("threeway");
        check("threeway.rs1_const", out_rs1_data, 32'h33);
        check("threeway.rs2_const", out_rs2_data, 32'h33);

        // Load-use stall, then release
        clear_in();
        set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h0);
        in_valid = 1'b1; in_instr = mk(7'h33, 5'd8, 5'd7, 5'd1); in_pc = 32'h104;
        #1;
        check("loaduse.stalled", {31'b0, in_ready}, 32'd0);
        step("loaduse1");
        check("loaduse.bubble", {31'b0, out_valid}, 32'd0);
        set_fwd(0, 1'b1, 1'b0, 5'd7, 32'hDEAD);
        step("loaduse2");
        check("loaduse.rs1_const", out_rs1_data, 32'hDEAD);

        // Shadowed pending source
        set_fwd(0, 1'b1, 1'b0, 5'd7, 32'hAAAA);
        set_fwd(1, 1'b1, 1'b1, 5'd7, 32'h5555);
        in_instr = mk(7'h33, 5'd9, 5'd7, 5'd0); in_pc = 32'h108;
        step("shadow");
        check("shadow.rs1_const", out_rs1_data, 32'hAAAA);

        // LUI ignores rs1; I-type ignores rs2
        clear_in();
        set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h77);
        in_valid = 1'b1; in_instr = mk(7'h37, 5'd3, 5'd7, 5'd7); in_pc = 32'h10C;
        step("lui");
        check("lui.no_stall", {31'b0, out_valid}, 32'd1);
        in_instr = mk(7'h13, 5'd4, 5'd3, 5'd7); in_pc = 32'h110;
        step("itype");
        check("itype.no_stall", out_instr, mk(7'h13, 5'd4, 5'd3, 5'd7));

        // Backpressure holds outputs for three cycles
        clear_in();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = mk(7'h33, 5'd1, 5'd2, 5'd3); in_pc = 32'h114;
        for (int i = 0; i < 3; i++) begin
            step("bp");
            check("bp.held_instr", out_instr, mk(7'h13, 5'd4, 5'd3, 5'd7));
        end
        // Flush with in_valid wins over acceptance
        flush = 1'b1;
        step("flush");
        check("flush.out_valid", {31'b0, out_valid}, 32'd0);
        check("flush.out_instr", out_instr, NOP);
        flush = 1'b0; out_ready = 1'b1;
        step("after_flush");

        // Asynchronous reset mid-stream, then register file reads 0
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        in_instr = mk(7'h33, 5'd1, 5'd5, 5'd6); in_pc = 32'h118;
        step("prereset");
        wb_en = 1'b0;
        #1 reset = 1'b1;
        #1 model_reset();
        check_outputs("midreset");
        check("midreset.instr_const", out_instr, 32'h33);
        reset = 1'b0;
        in_instr = mk(7'h33, 5'd1, 5'd5, 5'd6); in_pc = 32'h11C;
        step("rf_cleared");
        check("rf_cleared.rs1_const", out_rs1_data, 32'h0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom % 8) != 0;
            in_instr = mk(ops[$urandom % 8], 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8));
            in_instr[31:25] = 7'($urandom);
            in_instr[14:12] = 3'($urandom);
            in_pc = $urandom;
            for (int i = 0; i < NF; i++)
                set_fwd(i, 1'($urandom % 2), ($urandom % 5) == 0, 5'($urandom % 8), $urandom);
            wb_en = 1'($urandom % 2); wb_addr = 5'($urandom % 8); wb_data = $urandom;
            out_ready = ($urandom % 4) != 0;
            flush = ($urandom % 16) == 0;
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
# operand_stage

Parametrised decode/operand-read pipeline stage: the successor to the fixed three-source forwarding decode stage. It holds the architectural register file and resolves rs1/rs2 against NUM_FWD downstream forwarding sources, a writeback port and the file itself. It detects load-use hazards from sources whose data is not yet available and stalls upstream. A valid/ready registered output feeds the execute stage.

## Interface
- XLEN, 32: datapath width
- NUM_FWD, 3: forwarding sources; index 0 is the youngest (EX), index NUM_FWD-1 the oldest
- NOP_INSTR, 32'h0000_0033: instruction placed on out_instr at reset and flush (add x0,x0,x0)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  kill the output register and drop the input this cycle
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- fwd_valid  in  NUM_FWD  source i will write register fwd_rd[i]
- fwd_pending  in  NUM_FWD  source i result is not yet available (load in flight)
- fwd_rd  in  5*NUM_FWD  destination of source i, packed with i=0 in bits [4:0]
- fwd_data  in  XLEN*NUM_FWD  result of source i, packed
- wb_en, wb_addr[4:0], wb_data[XLEN]  in  register file write port
- out_valid  out  1  output register holds a valid instruction
- out_ready  in  1  execute stage consumes the output
- out_instr  out  32; out_pc  out  XLEN; out_rs1_data, out_rs2_data  out  XLEN

## Operation
- rs1 = instr[19:15], rs2 = instr[24:20], opcode = instr[6:0]
- rs1 is used unless opcode is LUI, AUIPC or JAL. rs2 is used only for R (0110011), S (0100011) and B (1100011).
- Operand selection, highest priority first:
  - rs==0: result is 0
  - lowest index i with fwd_valid[i] && fwd_rd[i]==rs: fwd_data[i]
  - wb_en && wb_addr==rs: wb_data
  - register file
- hazard = in_valid && a used rs is nonzero && its selected forwarding source has fwd_pending=1. A pending source shadowed by a younger non-pending match is no hazard.
- in_ready = !flush && !hazard && (!out_valid || out_ready)
- Register file: 31 × XLEN registers. Written on clk when wb_en && wb_addr!=0. The bypass above gives read-after-write in the same cycle.
- Output register update, in priority order:
  - flush: out_valid←0, out_instr←NOP_INSTR
  - accept (in_valid && in_ready): load instr, pc and both operands; out_valid←1
  - out_ready with no accept: out_valid←0, out_instr←NOP_INSTR; data fields hold
  - otherwise (out_valid && !out_ready): hold every output
- Operands are sampled only at accept. Holding stability under a downstream stall is the forwarding stages' responsibility.

## Timing
- Reset, asynchronous, all outputs cleared: out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_rs1_data=0, out_rs2_data=0. Register file cleared to 0.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle when out_ready=1 and no hazard.
- Hazard stall lasts while the pending bit stays set. Each stalled cycle with out_ready=1 emits a bubble.
- in_ready is combinational from in_instr, the fwd_* signals, flush, out_valid and out_ready.
- Simultaneous flush and accept: flush wins and the input is not consumed (in_ready=0).
- wb write and read of the same register in one cycle: the read returns wb_data.

## Configuration
- OPERAND_STAGE_PERF_EN
  - Defined: adds output stall_cycles [31:0]. It increments each cycle hazard=1, saturates at 32'hFFFF_FFFF and resets to 0.
  - Undefined: the port and counter are absent.

## Test plan
- Reset mid-stream with out_valid=1: outputs immediately become out_valid=0, out_instr=32'h33, operands 0. The register file reads 0 after reset.
- Three-way match on x5, with wb=0x11, fwd[2]=0x22, fwd[1]=0x33, fwd[0] not matching; ADD x6,x5,x5 accepted. Expect out_rs1_data = out_rs2_data = 0x33 next cycle.
- Load-use: fwd[0] valid with rd=x7 and pending=1, ADD using x7. Expect in_ready=0 and a bubble. Drop pending with fwd_data=0xDEAD. Expect accept and out_rs1_data=0xDEAD.
- Shadowing: fwd[0] rd=x7 not pending with data 0xAAAA, fwd[1] rd=x7 pending. Expect no stall and operand 0xAAAA.
- LUI x7 with fwd[0] rd=x7 pending, and an I-type whose rs2 field matches a pending rd. Expect no stall in either case.
- Backpressure and flush: hold out_ready=0 for 3 cycles and check outputs are held with in_ready=0. Assert flush together with in_valid: expect out_valid=0 and the instruction not consumed.
